// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART TX core among
// NUM_REQ byte sources. It grants one pending request and captures its byte.
// It then holds data-enable until the core reports busy and waits for the
// frame to end. If the core never starts, it aborts on a CE-tick timeout.
module uart_tx_sched #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned TIMEOUT_TICKS = 64
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       iCLK_CE,
  input  logic [NUM_REQ-1:0]         iREQ,
  input  logic [8*NUM_REQ-1:0]       iREQ_DATA,
  output logic [NUM_REQ-1:0]         oACK,
  output logic                       oTX_DE,
  output logic [7:0]                 oTX_DATA,
  input  logic                       iTX_BUSY,
  output logic                       oBUSY,
  output logic [$clog2(NUM_REQ)-1:0] oGNT_ID,
  output logic                       oDONE,
  output logic                       oERR
);

  localparam int unsigned GW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(TIMEOUT_TICKS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_DONE
  } state_t;

  state_t          state, state_n;
  logic [GW-1:0]   ptr, ptr_n;
  logic [CW-1:0]   cnt, cnt_n;

  logic [NUM_REQ-1:0] ack_n;
  logic               de_n;
  logic [7:0]         data_n;
  logic               busy_n;
  logic [GW-1:0]      gnt_n;
  logic               done_n;
  logic               err_n;

  logic               found;
  logic [GW-1:0]      win;
  logic [7:0]         sel_data;

  // Round-robin search: first pending request at or above ptr, wrapping to 0
  always_comb begin
    int unsigned   j;
    logic [GW-1:0] idx;
    found = 1'b0;
    win   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      idx = GW'(j);
      if (!found && iREQ[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Winner's byte slice
  always_comb begin
    sel_data = '1;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win == GW'(i)) sel_data = iREQ_DATA[i*8 +: 8];
    end
  end

  // Next-state and registered-output logic; pulses default low every cycle
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    ack_n   = '0;
    de_n    = oTX_DE;
    data_n  = oTX_DATA;
    busy_n  = oBUSY;
    gnt_n   = oGNT_ID;
    done_n  = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      S_IDLE: begin
        de_n = 1'b0;
        if (found) begin
          for (int unsigned i = 0; i < NUM_REQ; i++) ack_n[i] = (win == GW'(i));
          data_n  = sel_data;
          gnt_n   = win;
          ptr_n   = (win == GW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
          cnt_n   = '0;
          busy_n  = 1'b1;
          state_n = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (iTX_BUSY) begin
          de_n    = 1'b0;
          state_n = S_WAIT_DONE;
        end else if (cnt == CW'(TIMEOUT_TICKS)) begin
          de_n    = 1'b0;
          done_n  = 1'b1;
          err_n   = 1'b1;
          busy_n  = 1'b0;
          state_n = S_IDLE;
        end else begin
          de_n = 1'b1;
          // Only ticks the core could have launched on (DE already high) count
          if (iCLK_CE && oTX_DE) cnt_n = cnt + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        de_n = 1'b0;
        if (!iTX_BUSY) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = S_IDLE;
        end
      end
      default: begin
        de_n    = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      ptr      <= '0;
      cnt      <= '0;
      oACK     <= '0;
      oTX_DE   <= 1'b0;
      oTX_DATA <= '1;
      oBUSY    <= 1'b0;
      oGNT_ID  <= '0;
      oDONE    <= 1'b0;
      oERR     <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      cnt      <= cnt_n;
      oACK     <= ack_n;
      oTX_DE   <= de_n;
      oTX_DATA <= data_n;
      oBUSY    <= busy_n;
      oGNT_ID  <= gnt_n;
      oDONE    <= done_n;
      oERR     <= err_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: grant, handshake, fairness, timeout, reset.
module tb_uart_tx_sched;

  logic        CLK;
  logic        RST_N;
  logic        iCLK_CE;
  logic [3:0]  iREQ;
  logic [31:0] iREQ_DATA;
  logic [3:0]  oACK;
  logic        oTX_DE;
  logic [7:0]  oTX_DATA;
  logic        iTX_BUSY;
  logic        oBUSY;
  logic [1:0]  oGNT_ID;
  logic        oDONE;
  logic        oERR;

  int errors = 0;
  int checks = 0;

  uart_tx_sched #(.NUM_REQ(4), .TIMEOUT_TICKS(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .iCLK_CE(iCLK_CE),
    .iREQ(iREQ), .iREQ_DATA(iREQ_DATA), .oACK(oACK),
    .oTX_DE(oTX_DE), .oTX_DATA(oTX_DATA), .iTX_BUSY(iTX_BUSY),
    .oBUSY(oBUSY), .oGNT_ID(oGNT_ID), .oDONE(oDONE), .oERR(oERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full frame for requester eid carrying edata; iREQ is set by caller
  task automatic frame(input int eid, input logic [7:0] edata, input bit drop, input bit scramble);
    for (int k = 0; k < 8; k++) begin
      if (oACK != 4'b0) break;
      step();
    end
    chk("ack", 32'(oACK), 32'(1) << eid);
    chk("gnt_id", 32'(oGNT_ID), 32'(eid));
    chk("tx_data_capture", 32'(oTX_DATA), 32'(edata));
    chk("de_low_at_ack", 32'(oTX_DE), 32'd0);
    chk("busy_at_ack", 32'(oBUSY), 32'd1);
    chk("done_not_with_ack", 32'(oDONE), 32'd0);
    if (drop) iREQ = 4'b0;
    if (scramble) iREQ_DATA = $urandom;
    step();
    chk("de_high", 32'(oTX_DE), 32'd1);
    chk("ack_pulse_end", 32'(oACK), 32'd0);
    iTX_BUSY = 1'b1;
    step();
    chk("de_drop_on_busy", 32'(oTX_DE), 32'd0);
    for (int k = 0; k < 3; k++) begin
      if (scramble) iREQ_DATA = $urandom;
      step();
      chk("tx_data_hold", 32'(oTX_DATA), 32'(edata));
      chk("no_done_mid", 32'(oDONE), 32'd0);
      chk("de_low_wait", 32'(oTX_DE), 32'd0);
    end
    iTX_BUSY = 1'b0;
    step();
    chk("done", 32'(oDONE), 32'd1);
    chk("err_clear", 32'(oERR), 32'd0);
    chk("busy_clear", 32'(oBUSY), 32'd0);
    chk("ack_not_with_done", 32'(oACK), 32'd0);
  endtask

  initial begin
    RST_N     = 1'b0;
    iCLK_CE   = 1'b1;
    iREQ      = 4'b0;
    iREQ_DATA = 32'h0;
    iTX_BUSY  = 1'b0;
    step();
    step();
    chk("rst_ack", 32'(oACK), 32'd0);
    chk("rst_de", 32'(oTX_DE), 32'd0);
    chk("rst_data", 32'(oTX_DATA), 32'hFF);
    chk("rst_busy", 32'(oBUSY), 32'd0);
    chk("rst_gnt", 32'(oGNT_ID), 32'd0);
    chk("rst_done", 32'(oDONE), 32'd0);
    chk("rst_err", 32'(oERR), 32'd0);
    RST_N = 1'b1;
    step();

    // Single request on slice 1, input data churns after capture
    iREQ_DATA = 32'h00_00_A5_00;
    iREQ      = 4'b0010;
    frame(1, 8'hA5, 1'b1, 1'b1);

    // Fairness: ptr=2 -> grant 2, then 0101 searches from 3 and wraps to 0
    iREQ_DATA = {8'h43, 8'h32, 8'h21, 8'h10};
    iREQ      = 4'b0100;
    frame(2, 8'h32, 1'b1, 1'b0);
    iREQ = 4'b0101;
    frame(0, 8'h10, 1'b0, 1'b0);
    frame(2, 8'h32, 1'b1, 1'b0);

    // Reset asserted during WAIT_DONE; ptr=3 so requester 1 wins
    iREQ = 4'b0010;
    for (int k = 0; k < 8; k++) begin
      if (oACK != 4'b0) break;
      step();
    end
    chk("rstmid_gnt", 32'(oGNT_ID), 32'd1);
    iREQ = 4'b0;
    step();
    iTX_BUSY = 1'b1;
    step();
    chk("rstmid_in_wait", 32'(oBUSY), 32'd1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("rstmid_de", 32'(oTX_DE), 32'd0);
    chk("rstmid_busy", 32'(oBUSY), 32'd0);
    chk("rstmid_data", 32'(oTX_DATA), 32'hFF);
    chk("rstmid_gnt0", 32'(oGNT_ID), 32'd0);
    iTX_BUSY = 1'b0;
    iREQ     = 4'b1111;
    step();
    step();
    chk("rstmid_no_ack", 32'(oACK), 32'd0);
    RST_N = 1'b1;

    // All four requesting: grants cycle 0,1,2,3,0 starting from reset ptr
    frame(0, 8'h10, 1'b0, 1'b0);
    frame(1, 8'h21, 1'b0, 1'b0);
    frame(2, 8'h32, 1'b0, 1'b0);
    frame(3, 8'h43, 1'b0, 1'b0);
    frame(0, 8'h10, 1'b1, 1'b0);

    // Timeout: core never goes busy, CE every cycle, limit 8 ticks
    step();
    iREQ = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      if (oACK != 4'b0) break;
      step();
    end
    chk("to_ack", 32'(oACK), 32'b0001);
    iREQ = 4'b0;
    step();
    chk("to_de_rise", 32'(oTX_DE), 32'd1);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("to_de_held", 32'(oTX_DE), 32'd1);
      chk("to_no_done", 32'(oDONE), 32'd0);
    end
    step();
    chk("to_de_drop", 32'(oTX_DE), 32'd0);
    chk("to_done", 32'(oDONE), 32'd1);
    chk("to_err", 32'(oERR), 32'd1);
    chk("to_busy", 32'(oBUSY), 32'd0);
    step();
    chk("to_done_pulse", 32'(oDONE), 32'd0);
    chk("to_err_pulse", 32'(oERR), 32'd0);
    chk("to_idle_de", 32'(oTX_DE), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler sharing one 8-bit UART transmitter core among NUM_REQ byte sources (eye-position reporter, status/debug, command echo, …). It arbitrates pending requests, captures the winner's byte, sequences the core's data-enable/busy handshake so exactly one frame is emitted per grant, and recovers via timeout if the core never starts. It sits between the requesters and the UART TX core, and runs on the same clock and baud clock-enable as the core.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- TIMEOUT_TICKS, 64, iCLK_CE ticks allowed in LAUNCH before abort (≥2)
- CLK  in  1  system clock, all logic on rising edge
- RST_N  in  1  asynchronous active-low reset
- iCLK_CE  in  1  baud oversampling clock-enable, same signal fed to the TX core
- iREQ  in  NUM_REQ  per-requester level request; bit i high = byte pending on slice i
- iREQ_DATA  in  8*NUM_REQ  byte of requester i on bits [8i+7:8i]
- oACK  out  NUM_REQ  one-CLK pulse: requester's byte captured, slice may change
- oTX_DE  out  1  data-enable to TX core
- oTX_DATA  out  8  byte to TX core, held stable for the whole frame
- iTX_BUSY  in  1  busy from TX core
- oBUSY  out  1  high from grant until frame complete or abort
- oGNT_ID  out  clog2(NUM_REQ)  index of current/last granted requester
- oDONE  out  1  one-CLK pulse: frame finished (busy fell) or aborted
- oERR  out  1  one-CLK pulse coincident with oDONE when the frame was aborted by timeout

## Operation
- States: IDLE, LAUNCH, WAIT_DONE.
- IDLE: if any iREQ bit is high, pick the first set bit searching upward from pointer ptr, wrapping at NUM_REQ-1 → 0. In the same CLK: capture the winner's slice into oTX_DATA, pulse oACK[winner], load oGNT_ID, set ptr = (winner+1) mod NUM_REQ; next state LAUNCH. Arbitration is not qualified by iCLK_CE.
- LAUNCH: oTX_DE=1, oBUSY=1. The core launches on the rising edge of (DE & CE), so DE stays high until iTX_BUSY=1 is sampled; then DE drops and state becomes WAIT_DONE. CE-tick counter starts at 0 on entry; if it reaches TIMEOUT_TICKS with busy never seen, drop DE, pulse oDONE and oERR, return to IDLE.
- WAIT_DONE: oTX_DE=0 (prevents re-trigger when the core returns to idle); oTX_DATA held (the core reads data and parity from it mid-frame). On sampling iTX_BUSY=0: pulse oDONE, go to IDLE.
- Requests are not preemptible; a requester deasserting iREQ after oACK has no effect on the frame in progress.
- Timeout counter width is clog2(TIMEOUT_TICKS+1); it saturates and clears on LAUNCH entry.

## Timing
- Reset values: state IDLE, ptr 0, oACK 0, oTX_DE 0, oTX_DATA 8'hFF, oBUSY 0, oGNT_ID 0, oDONE 0, oERR 0.
- Grant latency: iREQ sampled high in IDLE at edge N → oACK high in the cycle after edge N; oTX_DE high from edge N+1.
- Back-to-back: oDONE cycle is spent returning to IDLE; next grant may occur at the following edge, so minimum 1 idle CLK between frames; DE is low ≥2 CLK between launches.
- Simultaneous requests: round-robin fairness; with all bits held high, grants cycle 0,1,2,…,NUM_REQ-1,0.
- iTX_BUSY already high when entering LAUNCH (core still busy): DE drops the next cycle and WAIT_DONE waits for the current busy period to end (no error); frame may be lost — requesters must not share the core through other paths.
- Reset mid-frame: all outputs return to reset values immediately; the core may finish its frame independently.
- oDONE and oERR never assert in the same cycle as oACK.

## Test plan
- Single request: iREQ=4'b0010, data1=8'hA5 → oACK=4'b0010 one cycle, oTX_DATA=8'hA5, DE high until busy, one frame 0xA5 on the line, oDONE once, oERR=0.
- All four requesting continuously with data 8'h10,8'h21,8'h32,8'h43 → frames emitted 10,21,32,43,10,… with oGNT_ID 0,1,2,3,0.
- Pointer fairness: grant requester 2, then iREQ=4'b0101 → requester 0 is not served before… next grant goes to 0 (search from 3 wraps to 0), then 2.
- Timeout: iTX_BUSY tied 0, TIMEOUT_TICKS=8 → DE high for 8 CE ticks, then DE=0, oDONE and oERR pulse together, state IDLE.
- Data stability: change iREQ_DATA every cycle after oACK → line frame equals the captured byte, parity (7-bit/odd settings on core) correct.
- Reset asserted during WAIT_DONE → oTX_DE=0, oBUSY=0, oTX_DATA=8'hFF, oGNT_ID=0 immediately; after release the first grant goes to requester 0.
